// File: rtl/cb_pkg.sv
// Shared definitions for the CRAZYBALLOON ROM download path.
// Holds the loader state encoding, image constants and the memory region
// bases used by the core to decode dn_addr into PROG / GFX / COLOR writes.
package cb_pkg;

  // Loader sequencing: wait, stream bytes, judge image, hold core, run.
  typedef enum logic [2:0] {
    CB_IDLE  = 3'd0,
    CB_LOAD  = 3'd1,
    CB_CHECK = 3'd2,
    CB_HOLD  = 3'd3,
    CB_RUN   = 3'd4
  } cb_ld_state_t;

  localparam int unsigned CB_IOCTL_ADDR_W = 25;
  localparam int unsigned CB_ADDR_W       = 16;
  localparam int unsigned CB_HOLD_CYCLES  = 1024;

  localparam logic [7:0]  CB_ROM_INDEX  = 8'd0;
  localparam logic [15:0] CB_IMAGE_SIZE = 16'h4000;

  // Region bases inside the downloaded image.
  localparam logic [15:0] CB_REGION_PROG  = 16'h0000;
  localparam logic [15:0] CB_REGION_GFX   = 16'h2000;
  localparam logic [15:0] CB_REGION_COLOR = 16'h3800;

  // True when a download byte address lies inside an image of the given size.
  function automatic logic cb_addr_in_image(
    input logic [CB_IOCTL_ADDR_W-1:0] addr,
    input logic [15:0]                size
  );
    return addr < CB_IOCTL_ADDR_W'(size);
  endfunction

endpackage

// File: rtl/cb_edge_det.sv
// Edge detector for the ioctl_downl level.
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   level_i   level to watch
//   rise_c_o  high in the cycle level_i is first seen high (combinational)
//   fall_c_o  high in the cycle level_i is first seen low (combinational)
// The previous level resets to 1 so a download already active when reset
// is released is not mistaken for a fresh start; the loader waits for a
// genuine low-to-high transition.
module cb_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic level_q;

  // Level history register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_c_o = level_i & ~level_q;
  assign fall_c_o = ~level_i & level_q;

endmodule

// File: rtl/cb_rom_loader.sv
// ROM download front-end for the CRAZYBALLOON core.
// Turns the data_io byte stream into single-cycle core write strobes,
// range-checks and counts the image, and keeps the core in reset during
// the download and for HOLD_CYCLES clocks after a good one.
// Ports:
//   clk_sys, reset_n            clock, asynchronous active-low reset
//   ioctl_downl/index/addr/dout/wr  download stream from data_io
//   dn_addr/dn_data/dn_wr       registered core write port (1-cycle latency)
//   dn_ld                       download-in-progress level to the core
//   core_reset                  active-high core reset request
//   load_done/load_error        sticky result of the last matching image
module cb_rom_loader
  import cb_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX   = CB_ROM_INDEX,
  parameter logic [15:0] IMAGE_SIZE  = CB_IMAGE_SIZE,
  parameter int unsigned ADDR_W      = CB_ADDR_W,
  parameter int unsigned HOLD_CYCLES = CB_HOLD_CYCLES
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_downl,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              dn_ld,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error
);

  // Counter must reach IMAGE_SIZE+1 to distinguish exact from oversize.
  localparam int unsigned CNT_W = 17;
  localparam int unsigned TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IMAGE_SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IMAGE_SIZE) + CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);

  cb_ld_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
  logic [7:0]        dn_data_q, dn_data_d;
  logic              dn_wr_q, dn_wr_d;
  logic              dn_ld_q, dn_ld_d;
  logic              core_reset_q, core_reset_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;

  logic              rise_c;
  logic              fall_c;
  logic              start_c;
  logic              in_image_c;

  cb_edge_det u_downl_edge (
    .clk_i    (clk_sys),
    .rst_ni   (reset_n),
    .level_i  (ioctl_downl),
    .rise_c_o (rise_c),
    .fall_c_o (fall_c)
  );

  // Only a download of our image index may start a load; others are invisible.
  assign start_c    = rise_c & (ioctl_index == ROM_INDEX);
  assign in_image_c = cb_addr_in_image(ioctl_addr, IMAGE_SIZE);

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    ovf_d        = ovf_q;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    dn_wr_d      = 1'b0;
    dn_ld_d      = dn_ld_q;
    core_reset_d = core_reset_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;

    unique case (state_q)
      CB_IDLE: begin
        core_reset_d = 1'b1;
        if (start_c) begin
          state_d      = CB_LOAD;
          cnt_d        = '0;
          ovf_d        = 1'b0;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          dn_ld_d      = 1'b1;
        end
      end

      CB_LOAD: begin
        // A byte arriving together with the falling edge is still taken.
        if (ioctl_wr) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (in_image_c) begin
            dn_wr_d   = 1'b1;
            dn_addr_d = ioctl_addr[ADDR_W-1:0];
            dn_data_d = ioctl_dout;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (fall_c) begin
          dn_ld_d = 1'b0;
          state_d = CB_CHECK;
        end
      end

      CB_CHECK: begin
        if ((cnt_q == CNT_FULL) && !ovf_q) begin
          load_done_d = 1'b1;
          tmr_d       = TMR_LOAD;
          state_d     = CB_HOLD;
        end else begin
          load_error_d = 1'b1;
          state_d      = CB_IDLE;
        end
      end

      CB_HOLD: begin
        core_reset_d = 1'b1;
        if (start_c) begin
          state_d      = CB_LOAD;
          cnt_d        = '0;
          ovf_d        = 1'b0;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          dn_ld_d      = 1'b1;
        end else if (tmr_q == '0) begin
          state_d = CB_RUN;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      CB_RUN: begin
        core_reset_d = 1'b0;
        if (start_c) begin
          state_d      = CB_LOAD;
          cnt_d        = '0;
          ovf_d        = 1'b0;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          dn_ld_d      = 1'b1;
          core_reset_d = 1'b1;
        end
      end

      default: begin
        state_d      = CB_IDLE;
        core_reset_d = 1'b1;
        dn_ld_d      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CB_IDLE;
      cnt_q        <= '0;
      tmr_q        <= '0;
      ovf_q        <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_wr_q      <= 1'b0;
      dn_ld_q      <= 1'b0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      ovf_q        <= ovf_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      dn_ld_q      <= dn_ld_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign dn_ld      = dn_ld_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_cb_rom_loader.sv
// Scoreboard bench for cb_rom_loader: the driver pushes every byte that
// should reach the core, a negedge monitor pops and compares each dn_wr.
module tb_cb_rom_loader;

  localparam int unsigned IMG  = 16384;
  localparam int unsigned HOLD = 16;

  logic        clk_sys     = 1'b0;
  logic        reset_n     = 1'b1;
  logic        ioctl_downl = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr  = '0;
  logic [7:0]  ioctl_dout  = 8'd0;
  logic        ioctl_wr    = 1'b0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_ld;
  logic        core_reset;
  logic        load_done;
  logic        load_error;

  cb_rom_loader #(
    .ROM_INDEX   (8'd0),
    .IMAGE_SIZE  (16'h4000),
    .ADDR_W      (16),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ioctl_downl (ioctl_downl),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_wr       (dn_wr),
    .dn_ld       (dn_ld),
    .core_reset  (core_reset),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [31:0] due;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  logic        exp_ld   = 1'b0;
  logic        prev_wr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: dn_ld level every cycle, and each dn_wr against the scoreboard.
  always @(negedge clk_sys) begin
    exp_t e;
    cyc++;
    check("dn_ld_level", 32'(dn_ld), 32'(exp_ld));
    if (dn_wr === 1'b1) begin
      check("dn_wr_back_to_back", 32'(prev_wr), 32'(0));
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dn_wr actual addr=%0h data=%0h required no write", dn_addr, dn_data);
      end else begin
        e = exp_q.pop_front();
        check("dn_addr", 32'(dn_addr), 32'(e.addr));
        check("dn_data", 32'(dn_data), 32'(e.data));
        check("dn_wr_latency", cyc, e.due);
      end
    end
    prev_wr = dn_wr;
  end

  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk_sys); #1;
    ioctl_index = idx;
    ioctl_downl = 1'b1;
    @(posedge clk_sys); #1;
    if (idx == 8'd0) exp_ld = 1'b1;
  endtask

  // One byte; a byte is seen by the DUT at the next edge and its dn_wr is
  // visible at the negedge after that, two monitor ticks from now.
  task automatic send_byte(input logic [24:0] a, input logic [7:0] d,
                           input logic fwd, input logic last);
    @(posedge clk_sys); #1;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (last) ioctl_downl = 1'b0;
    if (fwd) exp_q.push_back('{addr: a[15:0], data: d, due: cyc + 2});
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    if (last) exp_ld = 1'b0;
  endtask

  // Whole download; last byte coincides with the falling edge of ioctl_downl.
  task automatic run_dl(input logic [7:0] idx, input int unsigned n,
                        input bit rdata, input bit rgap, output bit exp_done);
    bit match;
    bit over;
    logic [24:0] a;
    logic [7:0]  d;
    match = (idx == 8'd0);
    over  = 1'b0;
    start_dl(idx);
    for (int unsigned i = 0; i < n; i++) begin
      a = 25'(i);
      d = rdata ? 8'($urandom) : a[7:0];
      if (match && i >= IMG) over = 1'b1;
      send_byte(a, d, match && (i < IMG), i == n - 1);
      if (rgap) repeat ($urandom_range(0, 1)) @(posedge clk_sys);
    end
    exp_done = match && (n == IMG) && !over;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dn_addr"},    32'(dn_addr),    32'(0));
    check({tag, "_dn_data"},    32'(dn_data),    32'(0));
    check({tag, "_dn_wr"},      32'(dn_wr),      32'(0));
    check({tag, "_dn_ld"},      32'(dn_ld),      32'(0));
    check({tag, "_core_reset"}, 32'(core_reset), 32'(1));
    check({tag, "_load_done"},  32'(load_done),  32'(0));
    check({tag, "_load_error"}, 32'(load_error), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int unsigned n;

    // Reset and release.
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    check_reset_values("post_reset");

    // Bytes with ioctl_downl low are ignored.
    for (int i = 0; i < 5; i++) send_byte(25'($urandom_range(0, 255)), 8'($urandom), 1'b0, 1'b0);

    // Undersize image.
    run_dl(8'd0, 100, 1'b1, 1'b1, done);
    repeat (3) @(posedge clk_sys);
    #1;
    check("under_load_done",  32'(load_done),  32'(done));
    check("under_load_error", 32'(load_error), 32'(!done));
    check("under_core_reset", 32'(core_reset), 32'(1));

    // Wrong index leaves everything untouched.
    run_dl(8'd1, 100, 1'b1, 1'b1, done);
    repeat (3) @(posedge clk_sys);
    #1;
    check("wrongidx_load_done",  32'(load_done),  32'(0));
    check("wrongidx_load_error", 32'(load_error), 32'(1));
    check("wrongidx_core_reset", 32'(core_reset), 32'(1));

    // Reset in the middle of a download.
    start_dl(8'd0);
    for (int unsigned i = 0; i < 50; i++) send_byte(25'(i), 8'($urandom), 1'b1, 1'b0);
    repeat (3) @(posedge clk_sys);
    #1;
    check("mid_pending_writes", 32'(exp_q.size()), 32'(0));
    reset_n = 1'b0;
    exp_ld  = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    // Download still high after reset: abandoned, nothing forwarded.
    for (int unsigned i = 50; i < 55; i++) send_byte(25'(i), 8'($urandom), 1'b0, 1'b0);
    check("abandoned_load_done",  32'(load_done),  32'(0));
    check("abandoned_core_reset", 32'(core_reset), 32'(1));
    @(posedge clk_sys); #1;
    ioctl_downl = 1'b0;
    repeat (2) @(posedge clk_sys);

    // Fresh full nominal load; measure the core reset release.
    run_dl(8'd0, IMG, 1'b0, 1'b0, done);
    n = 0;
    while (load_done !== 1'b1 && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    check("nominal_load_done",  32'(load_done),  32'(done));
    check("nominal_load_error", 32'(load_error), 32'(!done));
    n = 0;
    while (core_reset !== 1'b0 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check("nominal_reset_release_cycles", n, HOLD + 1);
    check("nominal_core_reset", 32'(core_reset), 32'(0));

    // Wrong index while running.
    run_dl(8'd1, 20, 1'b1, 1'b1, done);
    repeat (3) @(posedge clk_sys);
    #1;
    check("run_wrongidx_core_reset", 32'(core_reset), 32'(0));
    check("run_wrongidx_load_done",  32'(load_done),  32'(1));

    // Oversize image started from RUN.
    run_dl(8'd0, IMG + 1, 1'b1, 1'b0, done);
    repeat (3) @(posedge clk_sys);
    #1;
    check("over_load_error", 32'(load_error), 32'(!done));
    check("over_load_done",  32'(load_done),  32'(done));
    check("over_core_reset", 32'(core_reset), 32'(1));
    repeat (HOLD + 4) @(posedge clk_sys);
    #1;
    check("over_core_reset_kept", 32'(core_reset), 32'(1));
    check("final_pending_writes", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
